// File: rtl/hpi_pkg.sv
// Shared types, HPI register map and parameter helpers for the HPI bus master.
package hpi_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAITW,
    ST_SETUP,
    ST_STROBE,
    ST_HOLD,
    ST_RECOVER,
    ST_DONE
  } hpi_state_e;

  // HPI register addresses of the USB host controller
  localparam logic [1:0] HPI_DATA    = 2'd0;
  localparam logic [1:0] HPI_MAILBOX = 2'd1;
  localparam logic [1:0] HPI_ADDRESS = 2'd2;
  localparam logic [1:0] HPI_STATUS  = 2'd3;

  // Every timed phase must last at least one cycle
  function automatic bit cyc_params_ok(input int setup_cyc, input int strobe_cyc,
                                       input int hold_cyc, input int recover_cyc);
    return (setup_cyc >= 1) && (strobe_cyc >= 1) && (hold_cyc >= 1) && (recover_cyc >= 1);
  endfunction

  // Largest phase length, used to size the shared phase timer
  function automatic int max_cyc(input int a, input int b, input int c, input int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hpi_phase_timer.sv
// Loadable down-counter timing every HPI phase; expired while the count is 1.
module hpi_phase_timer #(
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [TW-1:0] load_val,
  output logic          expired
);

  logic [TW-1:0] count;

  // Load on phase entry, then count down and park at 1
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= TW'(1);
    end else if (load) begin
      count <= load_val;
    end else if (count > TW'(1)) begin
      count <= count - TW'(1);
    end
  end

  assign expired = (count == TW'(1));

endmodule

// File: rtl/hpi_bus_master.sv
// HPI bus master: turns burst commands and a write-data stream into
// setup/strobe/hold/recover cycles on the host-port pins.
module hpi_bus_master
  import hpi_pkg::*;
#(
  parameter int DATA_W      = 16,
  parameter int ADDR_W      = 2,
  parameter int LEN_W       = 8,
  parameter int SETUP_CYC   = 1,
  parameter int STROBE_CYC  = 4,
  parameter int HOLD_CYC    = 1,
  parameter int RECOVER_CYC = 1
) (
  input  logic              clk_clk,
  input  logic              reset_reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  output logic              done,
  output logic              busy,
  output logic              hpi_cs_n,
  output logic              hpi_r_n,
  output logic              hpi_w_n,
  output logic [ADDR_W-1:0] hpi_addr,
  output logic [DATA_W-1:0] hpi_data_out,
  output logic              hpi_data_oe,
  input  logic [DATA_W-1:0] hpi_data_in
);

  localparam int MAX_CYC = max_cyc(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC);
  localparam int TW      = $clog2(MAX_CYC) + 1;

  if (!cyc_params_ok(SETUP_CYC, STROBE_CYC, HOLD_CYC, RECOVER_CYC)) begin : g_param_err
    $error("hpi_bus_master: SETUP/STROBE/HOLD/RECOVER_CYC must all be >= 1");
  end

  hpi_state_e        state;
  hpi_state_e        state_nxt;
  logic              cur_write;
  logic              write_nxt;
  logic [LEN_W-1:0]  beats_left;
  logic              tmr_load;
  logic [TW-1:0]     tmr_val;
  logic              tmr_expired;
  logic              accept;
  logic              wr_take;
  logic              capture;
  logic              beat_end;
  logic              pins_active;

  assign accept    = (state == ST_IDLE) && cmd_valid;
  assign wr_take   = (state == ST_WAITW) && wr_valid;
  assign capture   = (state == ST_STROBE) && tmr_expired && !cur_write;
  assign beat_end  = (state == ST_RECOVER) && tmr_expired;
  // Direction of the cycle being entered; a new command's direction applies immediately
  assign write_nxt = (state == ST_IDLE) ? cmd_write : cur_write;

  assign cmd_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);
  assign wr_ready  = wr_take;

  hpi_phase_timer #(
    .TW(TW)
  ) u_timer (
    .clk      (clk_clk),
    .rst      (reset_reset),
    .load     (tmr_load),
    .load_val (tmr_val),
    .expired  (tmr_expired)
  );

  // FSM state register
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode and phase timer reload on every state change
  always_comb begin
    state_nxt = state;
    tmr_load  = 1'b0;
    tmr_val   = TW'(1);
    unique case (state)
      ST_IDLE:    if (cmd_valid) state_nxt = cmd_write ? ST_WAITW : ST_SETUP;
      ST_WAITW:   if (wr_valid) state_nxt = ST_SETUP;
      ST_SETUP:   if (tmr_expired) state_nxt = ST_STROBE;
      ST_STROBE:  if (tmr_expired) state_nxt = ST_HOLD;
      ST_HOLD:    if (tmr_expired) state_nxt = ST_RECOVER;
      ST_RECOVER: begin
        if (tmr_expired) begin
          if (beats_left == '0) state_nxt = ST_DONE;
          else                  state_nxt = cur_write ? ST_WAITW : ST_SETUP;
        end
      end
      ST_DONE:    state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
    if (state_nxt != state) begin
      tmr_load = 1'b1;
      unique case (state_nxt)
        ST_SETUP:   tmr_val = TW'(SETUP_CYC);
        ST_STROBE:  tmr_val = TW'(STROBE_CYC);
        ST_HOLD:    tmr_val = TW'(HOLD_CYC);
        ST_RECOVER: tmr_val = TW'(RECOVER_CYC);
        default:    tmr_val = TW'(1);
      endcase
    end
  end

  // Command latch and beat counter; counter only decrements while beats remain
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      cur_write  <= 1'b0;
      beats_left <= '0;
      hpi_addr   <= '0;
    end else if (accept) begin
      cur_write  <= cmd_write;
      beats_left <= cmd_len;
      hpi_addr   <= cmd_addr;
    end else if (beat_end && (beats_left != '0)) begin
      beats_left <= beats_left - LEN_W'(1);
    end
  end

  assign pins_active = (state_nxt == ST_SETUP) || (state_nxt == ST_STROBE) ||
                       (state_nxt == ST_HOLD);

  // Pin and status registers, decoded from the state being entered so each
  // output is valid for exactly the cycles of its phase
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hpi_cs_n    <= 1'b1;
      hpi_r_n     <= 1'b1;
      hpi_w_n     <= 1'b1;
      hpi_data_oe <= 1'b0;
      done        <= 1'b0;
    end else begin
      hpi_cs_n    <= !pins_active;
      hpi_r_n     <= !((state_nxt == ST_STROBE) && !write_nxt);
      hpi_w_n     <= !((state_nxt == ST_STROBE) && write_nxt);
      hpi_data_oe <= pins_active && write_nxt;
      done        <= (state_nxt == ST_DONE);
    end
  end

  // Write data is latched when the beat's word is taken from the stream
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      hpi_data_out <= '0;
    end else if (wr_take) begin
      hpi_data_out <= wr_data;
    end
  end

  // Read data is sampled at the end of the last strobe cycle
  always_ff @(posedge clk_clk or posedge reset_reset) begin
    if (reset_reset) begin
      rd_data  <= '0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= capture;
      if (capture) rd_data <= hpi_data_in;
    end
  end

endmodule

// File: tb/tb_hpi_bus_master.sv
// Randomised bench for hpi_bus_master: each command is expanded into an
// expected per-cycle timeline from the phase lengths and compared cycle by cycle.
module tb_hpi_bus_master;

  localparam int B_SU = 2;
  localparam int B_SB = 7;
  localparam int B_HO = 3;
  localparam int B_RC = 2;

  logic        clk_clk = 1'b0;
  logic        reset_reset = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_write = 1'b0;
  logic [1:0]  cmd_addr = '0;
  logic [7:0]  cmd_len = '0;
  logic [15:0] wr_data = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] hpi_data_in = '0;

  logic        a_cmd_ready, a_wr_ready, a_rd_valid, a_done, a_busy, a_cs_n, a_r_n, a_w_n, a_oe;
  logic [15:0] a_rd_data, a_dout;
  logic [1:0]  a_addr;
  logic        b_cmd_ready, b_wr_ready, b_rd_valid, b_done, b_busy, b_cs_n, b_r_n, b_w_n, b_oe;
  logic [15:0] b_rd_data, b_dout;
  logic [1:0]  b_addr;

  always #5 clk_clk = ~clk_clk;

  hpi_bus_master u_dut_a (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(a_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(a_wr_ready),
    .rd_data(a_rd_data), .rd_valid(a_rd_valid), .done(a_done), .busy(a_busy),
    .hpi_cs_n(a_cs_n), .hpi_r_n(a_r_n), .hpi_w_n(a_w_n), .hpi_addr(a_addr),
    .hpi_data_out(a_dout), .hpi_data_oe(a_oe), .hpi_data_in(hpi_data_in)
  );

  hpi_bus_master #(
    .SETUP_CYC(B_SU), .STROBE_CYC(B_SB), .HOLD_CYC(B_HO), .RECOVER_CYC(B_RC)
  ) u_dut_b (
    .clk_clk(clk_clk), .reset_reset(reset_reset),
    .cmd_valid(cmd_valid), .cmd_ready(b_cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(b_wr_ready),
    .rd_data(b_rd_data), .rd_valid(b_rd_valid), .done(b_done), .busy(b_busy),
    .hpi_cs_n(b_cs_n), .hpi_r_n(b_r_n), .hpi_w_n(b_w_n), .hpi_addr(b_addr),
    .hpi_data_out(b_dout), .hpi_data_oe(b_oe), .hpi_data_in(hpi_data_in)
  );

  // Strobes are mutually exclusive and only ever low inside a chip select
  always @(negedge clk_clk) begin
    if (!reset_reset) begin
      assert (a_r_n || a_w_n) else $error("dut_a: r_n and w_n low together");
      assert (!a_cs_n || (a_r_n && a_w_n)) else $error("dut_a: strobe low with cs_n high");
      assert (b_r_n || b_w_n) else $error("dut_b: r_n and w_n low together");
      assert (!b_cs_n || (b_r_n && b_w_n)) else $error("dut_b: strobe low with cs_n high");
    end
  end

  // Observed outputs of whichever DUT is under test
  logic        sel = 1'b0;
  logic        o_cmd_ready, o_wr_ready, o_rd_valid, o_done, o_busy, o_cs_n, o_r_n, o_w_n, o_oe;
  logic [15:0] o_rd_data, o_dout;
  logic [1:0]  o_addr;
  assign o_cmd_ready = sel ? b_cmd_ready : a_cmd_ready;
  assign o_wr_ready  = sel ? b_wr_ready  : a_wr_ready;
  assign o_rd_valid  = sel ? b_rd_valid  : a_rd_valid;
  assign o_done      = sel ? b_done      : a_done;
  assign o_busy      = sel ? b_busy      : a_busy;
  assign o_cs_n      = sel ? b_cs_n      : a_cs_n;
  assign o_r_n       = sel ? b_r_n       : a_r_n;
  assign o_w_n       = sel ? b_w_n       : a_w_n;
  assign o_oe        = sel ? b_oe        : a_oe;
  assign o_rd_data   = sel ? b_rd_data   : a_rd_data;
  assign o_dout      = sel ? b_dout      : a_dout;
  assign o_addr      = sel ? b_addr      : a_addr;

  // One cycle of the reference timeline: inputs to drive and outputs expected
  typedef struct packed {
    logic        cmd_valid, cmd_write;
    logic [1:0]  cmd_addr;
    logic [7:0]  cmd_len;
    logic        wr_valid;
    logic [15:0] wr_data, data_in;
    logic        cs_n, r_n, w_n, oe, rd_valid, done, busy, cmd_ready, wr_ready, chk_addr;
    logic [15:0] data_out, rd_data;
    logic [1:0]  addr;
  } cyc_t;

  cyc_t        tl[$];
  logic [15:0] fixed_wd[$];
  logic [15:0] fixed_rd[$];
  int          su = 1, sb = 4, ho = 1, rc = 1;
  int          n_chk = 0;
  int          n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic cyc_t rec_base(input bit is_busy);
    cyc_t r;
    r.cmd_valid = 1'b0;          r.cmd_write = 1'($urandom);
    r.cmd_addr  = 2'($urandom);  r.cmd_len   = 8'($urandom);
    r.wr_valid  = 1'($urandom);  r.wr_data   = 16'($urandom);
    r.data_in   = 16'($urandom);
    r.cs_n = 1'b1; r.r_n = 1'b1; r.w_n = 1'b1; r.oe = 1'b0;
    r.rd_valid = 1'b0; r.done = 1'b0; r.busy = is_busy; r.cmd_ready = !is_busy;
    r.wr_ready = 1'b0; r.chk_addr = is_busy;
    r.data_out = '0; r.rd_data = '0; r.addr = '0;
    return r;
  endfunction

  task automatic add_idle(input bit v, input bit w, input logic [1:0] a, input int len);
    cyc_t r;
    r = rec_base(1'b0);
    r.cmd_valid = v;
    if (v) begin
      r.cmd_write = w; r.cmd_addr = a; r.cmd_len = 8'(len);
    end
    tl.push_back(r);
  endtask

  function automatic cyc_t beat_rec(input bit hold, input logic [1:0] a);
    cyc_t r;
    r = rec_base(1'b1);
    r.cmd_valid = hold;
    r.addr = a;
    return r;
  endfunction

  // Expected cycles of a whole burst, from WAITW/SETUP of beat 0 through DONE
  task automatic add_burst(input bit w, input logic [1:0] a, input int len,
                           input int max_stall, input int stall1, input bit hold);
    cyc_t        r;
    logic [15:0] d, q;
    int          ns;
    for (int b = 0; b <= len; b++) begin
      d = '0; q = '0;
      if (w) begin
        ns = (b == 1 && stall1 >= 0) ? stall1 : int'($urandom_range(max_stall, 0));
        for (int i = 0; i < ns; i++) begin
          r = beat_rec(hold, a); r.wr_valid = 1'b0; tl.push_back(r);
        end
        d = (fixed_wd.size() > 0) ? fixed_wd.pop_front() : 16'($urandom);
        r = beat_rec(hold, a); r.wr_valid = 1'b1; r.wr_data = d; r.wr_ready = 1'b1;
        tl.push_back(r);
      end
      for (int i = 0; i < su; i++) begin
        r = beat_rec(hold, a); r.cs_n = 1'b0; r.oe = w; r.data_out = d; tl.push_back(r);
      end
      for (int i = 0; i < sb; i++) begin
        r = beat_rec(hold, a); r.cs_n = 1'b0; r.oe = w; r.data_out = d;
        r.r_n = w; r.w_n = !w;
        if (!w && i == sb - 1) begin
          if (fixed_rd.size() > 0) r.data_in = fixed_rd.pop_front();
          q = r.data_in;
        end
        tl.push_back(r);
      end
      for (int i = 0; i < ho; i++) begin
        r = beat_rec(hold, a); r.cs_n = 1'b0; r.oe = w; r.data_out = d;
        if (!w && i == 0) begin
          r.rd_valid = 1'b1; r.rd_data = q;
        end
        tl.push_back(r);
      end
      for (int i = 0; i < rc; i++) begin
        r = beat_rec(hold, a); tl.push_back(r);
      end
    end
    r = beat_rec(hold, a); r.done = 1'b1; tl.push_back(r);
  endtask

  // Play the timeline (all of it when max_n < 0); entered at posedge+1
  task automatic run_q(input int max_n, output int done_at);
    cyc_t r;
    int   cyc;
    cyc = 0; done_at = -1;
    while (tl.size() > 0 && (max_n < 0 || cyc < max_n)) begin
      r = tl.pop_front();
      cmd_valid = r.cmd_valid; cmd_write = r.cmd_write; cmd_addr = r.cmd_addr;
      cmd_len = r.cmd_len; wr_valid = r.wr_valid; wr_data = r.wr_data;
      hpi_data_in = r.data_in;
      #1;
      chk("cs_n", o_cs_n, r.cs_n);
      chk("r_n", o_r_n, r.r_n);
      chk("w_n", o_w_n, r.w_n);
      chk("data_oe", o_oe, r.oe);
      chk("busy", o_busy, r.busy);
      chk("cmd_ready", o_cmd_ready, r.cmd_ready);
      chk("wr_ready", o_wr_ready, r.wr_ready);
      chk("done", o_done, r.done);
      chk("rd_valid", o_rd_valid, r.rd_valid);
      if (r.oe) chk("data_out", o_dout, r.data_out);
      if (r.rd_valid) chk("rd_data", o_rd_data, r.rd_data);
      if (r.chk_addr) chk("hpi_addr", o_addr, r.addr);
      if (o_done && done_at < 0) done_at = cyc;
      @(posedge clk_clk); #1;
      cyc++;
    end
    if (max_n < 0) begin
      cmd_valid = 1'b0; wr_valid = 1'b0;
    end
  endtask

  task automatic select(input bit s);
    sel = s;
    if (s) begin su = B_SU; sb = B_SB; ho = B_HO; rc = B_RC; end
    else   begin su = 1;    sb = 4;    ho = 1;    rc = 1;    end
  endtask

  // Reset both DUTs and check the reset values of the one under test
  task automatic do_reset();
    cmd_valid = 1'b0; wr_valid = 1'b0;
    reset_reset = 1'b1;
    @(posedge clk_clk); #1;
    chk("rst_cs_n", o_cs_n, 1'b1);
    chk("rst_r_n", o_r_n, 1'b1);
    chk("rst_w_n", o_w_n, 1'b1);
    chk("rst_oe", o_oe, 1'b0);
    chk("rst_addr", o_addr, 2'd0);
    chk("rst_dout", o_dout, 16'd0);
    chk("rst_rd_data", o_rd_data, 16'd0);
    chk("rst_rd_valid", o_rd_valid, 1'b0);
    chk("rst_done", o_done, 1'b0);
    chk("rst_wr_ready", o_wr_ready, 1'b0);
    chk("rst_busy", o_busy, 1'b0);
    chk("rst_cmd_ready", o_cmd_ready, 1'b1);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;
  endtask

  task automatic random_cmds(input int n, input int max_len);
    int  d, len;
    bit  w;
    logic [1:0] a;
    for (int k = 0; k < n; k++) begin
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) add_idle(1'b0, 1'b0, 2'd0, 0);
      run_q(-1, d);
      w = 1'($urandom); a = 2'($urandom); len = int'($urandom_range(max_len, 0));
      add_idle(1'b1, w, a, len);
      add_burst(w, a, len, 3, -1, 1'b0);
      run_q(-1, d);
      if (!w) chk("rand_rd_done_cyc", d, (su + sb + ho + rc) * (len + 1) + 1);
    end
  endtask

  int d;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    select(1'b0);
    do_reset();

    // single write to HPI_ADDRESS with data 0x1000
    fixed_wd.push_back(16'h1000);
    add_idle(1'b1, 1'b1, 2'd2, 0);
    add_burst(1'b1, 2'd2, 0, 0, -1, 1'b0);
    add_idle(1'b0, 1'b0, 2'd0, 0);
    run_q(-1, d);
    chk("wr1_done_cyc", d, 9);

    // 4-beat read from HPI_DATA
    fixed_rd.push_back(16'hA0A0); fixed_rd.push_back(16'hA0A1);
    fixed_rd.push_back(16'hA0A2); fixed_rd.push_back(16'hA0A3);
    add_idle(1'b1, 1'b0, 2'd0, 3);
    add_burst(1'b0, 2'd0, 3, 0, -1, 1'b0);
    add_idle(1'b0, 1'b0, 2'd0, 0);
    run_q(-1, d);
    chk("rd4_done_cyc", d, 29);

    // two-beat write with wr_valid withheld for 5 cycles before beat 1
    add_idle(1'b1, 1'b1, 2'd1, 1);
    add_burst(1'b1, 2'd1, 1, 0, 5, 1'b0);
    add_idle(1'b0, 1'b0, 2'd0, 0);
    run_q(-1, d);
    chk("stall_done_cyc", d, 8 * 2 + 1 + 5);

    // back-to-back: cmd_valid held through the first burst
    add_idle(1'b1, 1'b0, 2'd3, 1);
    add_burst(1'b0, 2'd3, 1, 0, -1, 1'b1);
    add_idle(1'b1, 1'b1, 2'd2, 1);
    add_burst(1'b1, 2'd2, 1, 0, -1, 1'b0);
    add_idle(1'b0, 1'b0, 2'd0, 0);
    run_q(-1, d);
    chk("b2b_done_cyc", d, 15);

    random_cmds(15, 5);

    // longest bursts: the beat counter must not wrap
    add_idle(1'b1, 1'b0, 2'd1, 255);
    add_burst(1'b0, 2'd1, 255, 0, -1, 1'b0);
    run_q(-1, d);
    chk("max_rd_done_cyc", d, 7 * 256 + 1);
    add_idle(1'b1, 1'b1, 2'd0, 255);
    add_burst(1'b1, 2'd0, 255, 0, -1, 1'b0);
    run_q(-1, d);
    chk("max_wr_done_cyc", d, 8 * 256 + 1);

    // reset during the strobe of a write burst
    add_idle(1'b1, 1'b1, 2'd1, 2);
    add_burst(1'b1, 2'd1, 2, 0, -1, 1'b0);
    run_q(5, d);
    tl.delete();
    chk("pre_rst_w_n", o_w_n, 1'b0);
    chk("pre_rst_cs_n", o_cs_n, 1'b0);
    cmd_valid = 1'b0; wr_valid = 1'b0;
    #2 reset_reset = 1'b1;
    #1;
    chk("async_rst_cs_n", o_cs_n, 1'b1);
    chk("async_rst_w_n", o_w_n, 1'b1);
    chk("async_rst_oe", o_oe, 1'b0);
    chk("async_rst_busy", o_busy, 1'b0);
    chk("async_rst_cmd_ready", o_cmd_ready, 1'b1);
    @(posedge clk_clk);
    @(negedge clk_clk);
    reset_reset = 1'b0;
    @(posedge clk_clk); #1;
    for (int i = 0; i < 4; i++) add_idle(1'b0, 1'b0, 2'd0, 0);
    run_q(-1, d);
    chk("rst_no_done", d, -1);
    add_idle(1'b1, 1'b1, 2'd3, 0);
    add_burst(1'b1, 2'd3, 0, 0, -1, 1'b0);
    run_q(-1, d);
    chk("post_rst_done_cyc", d, 9);

    // stretched timing on the second instance
    select(1'b1);
    do_reset();
    add_idle(1'b1, 1'b0, 2'd2, 0);
    add_burst(1'b0, 2'd2, 0, 0, -1, 1'b0);
    run_q(-1, d);
    chk("sweep_rd_done_cyc", d, B_SU + B_SB + B_HO + B_RC + 1);
    add_idle(1'b1, 1'b1, 2'd1, 2);
    add_burst(1'b1, 2'd1, 2, 0, -1, 1'b0);
    run_q(-1, d);
    chk("sweep_wr_done_cyc", d, (B_SU + B_SB + B_HO + B_RC + 1) * 3 + 1);
    random_cmds(8, 4);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
